imem_fetch_sequencer: RTL and testbench

- Fetch controller that sequences the synchronous instruction memory (word-addressed, 10-bit address, 32-bit data, one-cycle read latency) for the MIPS core.
- Generates sequential fetch addresses, accepts branch/jump redirects, honours halt, and buffers returned words in a small prefetch queue.
- Presents instructions to decode over a valid/ready handshake.

---
 rtl/imem_fetch_sequencer_if.sv | 28 ++
 rtl/imem_fetch_sequencer.sv | 87 ++++++++
 tb/tb_imem_fetch_sequencer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/imem_fetch_sequencer_if.sv
// Fetch sequencer bus: instruction-memory port, redirect/halt control and the
// decode-side valid/ready handshake.
interface imem_fetch_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10
);
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  redirect_valid;
  logic [ADDR_WIDTH-1:0] redirect_addr;
  logic                  halt;
  logic                  instr_valid;
  logic [DATA_WIDTH-1:0] instr_data;
  logic [ADDR_WIDTH-1:0] instr_pc;
  logic                  instr_ready;
  logic                  busy;

  modport master (
    output mem_addr, mem_rd_en, instr_valid, instr_data, instr_pc, busy,
    input  mem_data, redirect_valid, redirect_addr, halt, instr_ready
  );

  modport slave (
    input  mem_addr, mem_rd_en, instr_valid, instr_data, instr_pc, busy,
    output mem_data, redirect_valid, redirect_addr, halt, instr_ready
  );
endinterface

// File: rtl/imem_fetch_sequencer.sv
// Instruction fetch sequencer: issues sequential reads to a one-cycle-latency
// instruction memory and buffers returned words in a small prefetch queue.
module imem_fetch_sequencer #(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 10,
  parameter int                    QUEUE_DEPTH = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  imem_fetch_sequencer_if.master bus
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  logic [ADDR_WIDTH-1:0] fetch_pc;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic [CNT_W-1:0]      count;
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [DATA_WIDTH-1:0] q_data [QUEUE_DEPTH];
  logic [ADDR_WIDTH-1:0] q_pc   [QUEUE_DEPTH];

  logic             q_nonempty;
  logic             pop;
  logic             issue;
  logic             squash;
  logic             ret_wr;
  logic [OCC_W-1:0] occ;

  always_comb begin
    q_nonempty = (count != '0);
    pop        = q_nonempty & bus.instr_ready;
    occ        = OCC_W'(count) + OCC_W'(inflight) - OCC_W'(pop);
    issue      = rst_n & ~bus.halt & ~bus.redirect_valid
                 & (occ < OCC_W'(QUEUE_DEPTH));
    // With one-cycle latency the in-flight word is on mem_data during the
    // redirect cycle itself, so the squash kills that return directly.
    squash     = bus.redirect_valid;
    ret_wr     = inflight & ~squash;
  end

  assign bus.mem_addr    = fetch_pc;
  assign bus.mem_rd_en   = issue;
  assign bus.instr_valid = q_nonempty;
  assign bus.instr_data  = q_nonempty ? q_data[rd_ptr] : '0;
  assign bus.instr_pc    = q_nonempty ? q_pc[rd_ptr]   : '0;
  assign bus.busy        = inflight | q_nonempty;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else begin
      inflight <= issue;
      if (issue) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
      if (bus.redirect_valid) begin
        fetch_pc <= bus.redirect_addr;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
      end else begin
        if (pop)    rd_ptr <= rd_ptr + 1'b1;
        if (ret_wr) wr_ptr <= wr_ptr + 1'b1;
        count <= count + CNT_W'(ret_wr) - CNT_W'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (ret_wr) begin
      q_data[wr_ptr] <= bus.mem_data;
      q_pc[wr_ptr]   <= inflight_pc;
    end
  end

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized bench for imem_fetch_sequencer against a queue-based model of
// the fetch/issue/redirect rules, with a synchronous memory model attached.
module tb_imem_fetch_sequencer;

  localparam int QD = 2;

  logic clk = 1'b0;
  logic rst_n;

  imem_fetch_sequencer_if #(.DATA_WIDTH(32), .ADDR_WIDTH(10)) bus ();

  imem_fetch_sequencer #(
    .DATA_WIDTH (32),
    .ADDR_WIDTH (10),
    .QUEUE_DEPTH(QD),
    .RESET_PC   (10'd0)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [1024];

  always @(posedge clk) begin
    if (bus.mem_rd_en) bus.mem_data <= mem[bus.mem_addr];
  end

  always @(negedge clk) begin
    if (rst_n) assert (dut.count <= QD) else $error("queue occupancy out of range");
  end

  int checks   = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: PCs of queued words, the outstanding read and the next PC.
  int unsigned mq[$];
  bit          m_infl;
  int unsigned m_infl_pc;
  int unsigned m_fpc;

  task automatic model_reset();
    mq.delete();
    m_infl    = 1'b0;
    m_infl_pc = 0;
    m_fpc     = 0;
  endtask

  // Called at posedge+1: drive inputs, check at negedge, advance model at posedge.
  task automatic step(input bit rv, input int unsigned ra, input bit h, input bit rdy);
    bit          pop;
    bit          iss;
    int          occ;
    int unsigned head_pc;
    logic [31:0] head_data;
    bus.redirect_valid = rv;
    bus.redirect_addr  = ra[9:0];
    bus.halt           = h;
    bus.instr_ready    = rdy;
    pop = rst_n && (mq.size() != 0) && rdy;
    occ = mq.size() + int'(m_infl) - int'(pop);
    iss = rst_n && !h && !rv && (occ < QD);
    head_pc   = 0;
    head_data = '0;
    if (mq.size() != 0) begin
      head_pc   = mq[0];
      head_data = mem[mq[0]];
    end
    @(negedge clk);
    check_eq("mem_rd_en",   bus.mem_rd_en,   iss);
    check_eq("mem_addr",    bus.mem_addr,    m_fpc);
    check_eq("instr_valid", bus.instr_valid, mq.size() != 0);
    check_eq("instr_pc",    bus.instr_pc,    head_pc);
    check_eq("instr_data",  bus.instr_data,  head_data);
    check_eq("busy",        bus.busy,        m_infl || (mq.size() != 0));
    @(posedge clk);
    if (!rst_n) begin
      model_reset();
    end else begin
      if (pop) void'(mq.pop_front());
      if (rv) begin
        mq.delete();
        m_fpc = ra % 1024;
      end else if (m_infl) begin
        mq.push_back(m_infl_pc);
      end
      m_infl = iss;
      if (iss) begin
        m_infl_pc = m_fpc;
        m_fpc     = (m_fpc + 1) % 1024;
      end
    end
    #1;
  endtask

  task automatic async_reset_check();
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_instr_valid", bus.instr_valid, 1'b0);
    check_eq("rst_busy",        bus.busy,        1'b0);
    check_eq("rst_mem_rd_en",   bus.mem_rd_en,   1'b0);
    check_eq("rst_instr_pc",    bus.instr_pc,    10'd0);
    check_eq("rst_instr_data",  bus.instr_data,  32'd0);
    check_eq("rst_mem_addr",    bus.mem_addr,    10'd0);
    model_reset();
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit h;
    rst_n              = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.halt           = 1'b0;
    bus.instr_ready    = 1'b1;
    bus.mem_data       = '0;
    for (int k = 0; k < 1024; k++) mem[k] = 32'(k + 'h100);
    model_reset();
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 1);
    rst_n = 1'b1;

    // free run: one word per cycle
    for (int i = 0; i < 40; i++) step(0, 0, 0, 1);

    // backpressure then resume
    for (int i = 0; i < 6; i++) step(0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1);

    // redirect while flowing and while the queue is full
    step(1, 'h200, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    step(1, 'h080, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // halt with a read in flight, redirect while halted, then release
    for (int i = 0; i < 5; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 1, 1);
    step(1, 'h150, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1);

    // address wrap
    step(1, 'h3FE, 0, 1);
    for (int i = 0; i < 8; i++) step(0, 0, 0, 1);

    // randomized mix
    h = 1'b0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 9) == 0) h = ~h;
      step($urandom_range(0, 19) == 0, $urandom_range(0, 1023), h,
           $urandom_range(0, 3) != 0);
    end

    // asynchronous reset with the queue full
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
    async_reset_check();
    for (int i = 0; i < 2; i++) step(0, 0, 0, 1);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) step(0, 0, 0, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
